uart_cmd_rx: RTL and testbench
==============================

# uart_cmd_rx

Receive side of the debug UART link: an 8N1 serial receiver plus a command decoder for the 4-byte frame (0xAA sync, x, y, z), clocked by the 12 MHz system clock. A host can then request downsampled frame-buffer reads over `dbg_rx` instead of pressing a button. Outputs are a decoded read request (`cmd_x`, `cmd_y`, `cmd_z`) with a one-cycle strobe, raw byte taps for debug, and error strobes.

## Interface
- `CLK_HZ`, 12000000, system clock frequency in Hz.
- `BAUD`, 115200, line rate; `DIV = CLK_HZ/BAUD` (integer, 104 at defaults).
- `TIMEOUT_BITS`, 16, maximum idle gap inside a packet, in bit times, before the decoder abandons it.

Ports:
- `sys_clk_i`  in  1  system clock, single clock domain.
- `sys_rst_n_i`  in  1  synchronous, active-low reset.
- `uart_rx`  in  1  asynchronous serial input; idles high.
- `rx_data`  out  8  last received byte.
- `rx_valid`  out  1  one-cycle strobe; `rx_data` is valid in that cycle.
- `frame_err`  out  1  one-cycle strobe when the stop bit is sampled low.
- `cmd_x`  out  6  decoded column.
- `cmd_y`  out  5  decoded row.
- `cmd_z`  out  2  decoded byte lane.
- `cmd_valid`  out  1  one-cycle strobe; the `cmd_*` fields are valid and held until the next strobe.
- `cmd_err`  out  1  one-cycle strobe on a range error or a timeout.

## Operation
- Reset values: all outputs 0. Byte FSM goes to IDLE, decoder to HUNT, all counters 0. The synchronizer flops reset to 1.
- `uart_rx` passes through a 2-FF synchronizer; everything below uses the synchronized signal `rxs`.
- Byte FSM:
  - IDLE: a falling edge on `rxs` moves to START and loads the counter with DIV/2−1.
  - START: when the counter expires, `rxs` is re-sampled. If it is high (glitch), return to IDLE with no strobe. If it is low, go to DATA and load DIV−1.
  - DATA: sample 8 bits LSB-first at each counter expiry, then go to STOP.
  - STOP: sample the stop bit. High gives `rx_valid`; low gives `frame_err`. Either way go to IDLE.
  - A new start bit is accepted in the cycle after the return to IDLE, so back-to-back bytes are supported.
- Decoder:
  - HUNT: waits for a 0xAA byte, then goes to GOT_SYNC.
  - GOT_SYNC: takes x, then goes to GOT_X.
  - GOT_X: takes y, then goes to GOT_Y.
  - GOT_Y: takes z, pulses `cmd_valid`, then returns to HUNT.
- Range rules:
  - x must be ≤ 39.
  - y must be ≤ 29.
  - z uses bits [7:2] = 0.
  - A violation pulses `cmd_err`. If the offending byte is 0xAA, go to GOT_SYNC (resync); otherwise go to HUNT.
- `frame_err` in any decoder state forces HUNT without pulsing `cmd_err`.
- Timeout: an idle counter runs in GOT_SYNC, GOT_X and GOT_Y and clears on every `rx_valid`. At TIMEOUT_BITS·DIV cycles it pulses `cmd_err` and forces HUNT.
- Reset asserted mid-byte or mid-packet discards all partial state. No strobe fires in the reset cycle.

## Timing
- Start-edge detection lags `uart_rx` by 2 cycles because of the synchronizer.
- `rx_valid` is asserted in the cycle after the mid-stop-bit sample, which is about 9.5·DIV + 3 cycles after the start edge.
- `cmd_valid` and `cmd_err` are registered and assert exactly 1 cycle after the `rx_valid` of the byte that triggers them.
- The `cmd_*` fields update in the same cycle as `cmd_valid`.
- There is no backpressure. The consumer must accept `cmd_valid` whenever it fires; at most one command is produced per 4 byte times.

## Configuration
- `UART_CMD_RX_PARITY_EN` defined:
  - The frame is 8E1, and the byte FSM gains a PARITY state between DATA and STOP.
  - On an even-parity mismatch the byte is dropped: no `rx_valid`, `frame_err` pulses, and the decoder goes to HUNT.
  - `rx_valid` latency grows by DIV.
- `UART_CMD_RX_PARITY_EN` undefined: the frame is 8N1 and the PARITY state is absent.

## Structure
- Shared package `uart_cmd_pkg` holds:
  - `SYNC_BYTE` = 8'hAA
  - `MAX_X` = 39
  - `MAX_Y` = 29
  - the byte-FSM state typedef (IDLE/START/DATA/PARITY/STOP)
  - the decoder state typedef (HUNT/GOT_SYNC/GOT_X/GOT_Y)
- Sub-module `uart_rx_byte` contains the synchronizer, the byte FSM and the bit counter, and drives `rx_data`, `rx_valid` and `frame_err`. The top-level module holds the decoder and the timeout counter.

## Test plan
- Reset: hold `sys_rst_n_i` low for 5 cycles with `uart_rx` high → all outputs 0, and no strobe for 2000 cycles after release.
- Single byte: send 0x55 at DIV=104 → exactly one `rx_valid` with `rx_data`=0x55, within 9.5·104+3 ±1 cycles of the start edge.
- Command: send back-to-back bytes AA 05 03 02 → one `cmd_valid` 1 cycle after the last `rx_valid`, with `cmd_x`=5, `cmd_y`=3, `cmd_z`=2.
- Errors:
  - Send AA with its stop bit driven low → `frame_err` pulses, no `rx_valid`.
  - Drive a 30-cycle low glitch on `uart_rx` → no activity at all.
- Resync: send AA AA 01 02 03 → one `cmd_err` (the second AA fails the x range check), then `cmd_valid` with x=1, y=2, z=3.
- Timeout: send AA 04, then idle for 16·104+1 cycles → `cmd_err` pulses. Sending 04 05 01 afterwards produces no `cmd_valid`.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// ---------------------------------------------------------------------------
// uart_cmd_pkg
// Shared constants and state encodings for the debug UART command receiver.
//   SYNC_BYTE   : first byte of every 4-byte command frame
//   MAX_X/MAX_Y : largest legal column / row value
//   rx_state_e  : byte-level receiver FSM states
//   dec_state_e : command decoder FSM states
// ---------------------------------------------------------------------------
package uart_cmd_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hAA;
    localparam logic [7:0] MAX_X     = 8'd39;
    localparam logic [7:0] MAX_Y     = 8'd29;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    typedef enum logic [1:0] {
        HUNT,
        GOT_SYNC,
        GOT_X,
        GOT_Y
    } dec_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// ---------------------------------------------------------------------------
// uart_rx_byte
// Serial byte receiver: 2-FF synchronizer, start/data/stop FSM, bit counter.
// Frame is 8N1 by default; with UART_CMD_RX_PARITY_EN defined it is 8E1 and
// a parity mismatch is reported through frame_err instead of rx_valid.
// Ports:
//   sys_clk_i   in   system clock
//   sys_rst_n_i in   synchronous active-low reset
//   uart_rx     in   asynchronous serial line, idles high
//   rx_data     out  last good byte received
//   rx_valid    out  one-cycle strobe, rx_data valid
//   frame_err   out  one-cycle strobe, bad stop bit (or bad parity)
// ---------------------------------------------------------------------------
module uart_rx_byte
    import uart_cmd_pkg::*;
#(
    parameter int DIV = 104
) (
    input  logic       sys_clk_i,
    input  logic       sys_rst_n_i,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam int            CW        = $clog2(DIV);
    localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(DIV - 1);

    logic          sync1_q, rxs_q, rxs_prev_q;
    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_err_q, parity_err_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          expired;

    // NOTE: state flops use non-blocking assignments only; the reset branch
    // sits inside the clocked block, so reset is synchronous.
    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_n_i) begin
            // Synchronizer resets to the idle line level so no false start.
            sync1_q      <= 1'b1;
            rxs_q        <= 1'b1;
            rxs_prev_q   <= 1'b1;
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            parity_err_q <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sync1_q      <= uart_rx;
            rxs_q        <= sync1_q;
            rxs_prev_q   <= rxs_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            parity_err_q <= parity_err_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign expired = (cnt_q == '0);

    // NOTE: every signal written here gets a default first, so no latches.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        parity_err_d = parity_err_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        frame_err_d  = 1'b0;

        // The counter free-runs down in every busy state; expiry reloads it.
        if (state_q != IDLE && !expired) begin
            cnt_d = cnt_q - 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (rxs_prev_q && !rxs_q) begin
                    state_d = START;
                    cnt_d   = HALF_LOAD;
                end
            end
            START: begin
                // Mid-start-bit re-check rejects short glitches.
                if (expired) begin
                    if (rxs_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d      = DATA;
                        cnt_d        = FULL_LOAD;
                        bit_idx_d    = '0;
                        parity_err_d = 1'b0;
                    end
                end
            end
            DATA: begin
                if (expired) begin
                    shift_d = {rxs_q, shift_q[7:1]};
                    cnt_d   = FULL_LOAD;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_CMD_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            PARITY: begin
`ifdef UART_CMD_RX_PARITY_EN
                if (expired) begin
                    // Even parity: data plus parity bit must have even weight.
                    parity_err_d = ^{shift_q, rxs_q};
                    state_d      = STOP;
                    cnt_d        = FULL_LOAD;
                end
`else
                state_d = IDLE;
`endif
            end
            STOP: begin
                if (expired) begin
                    state_d = IDLE;
                    if (rxs_q && !parity_err_q) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = shift_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: rtl/uart_cmd_rx.sv
// ---------------------------------------------------------------------------
// uart_cmd_rx
// Debug UART receive path: byte receiver plus decoder for the 4-byte command
// frame (0xAA, x, y, z). Emits a registered read request with a strobe, raw
// byte taps and error strobes. Optional 8E1 framing: UART_CMD_RX_PARITY_EN.
// Ports:
//   sys_clk_i   in   12 MHz system clock
//   sys_rst_n_i in   synchronous active-low reset
//   uart_rx     in   asynchronous serial input, idles high
//   rx_data     out  last received byte
//   rx_valid    out  byte strobe
//   frame_err   out  framing (or parity) error strobe
//   cmd_x/y/z   out  decoded column / row / byte lane, held between strobes
//   cmd_valid   out  command strobe
//   cmd_err     out  range error or inter-byte timeout strobe
// ---------------------------------------------------------------------------
module uart_cmd_rx
    import uart_cmd_pkg::*;
#(
    parameter int CLK_HZ       = 12000000,
    parameter int BAUD         = 115200,
    parameter int TIMEOUT_BITS = 16
) (
    input  logic       sys_clk_i,
    input  logic       sys_rst_n_i,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic [5:0] cmd_x,
    output logic [4:0] cmd_y,
    output logic [1:0] cmd_z,
    output logic       cmd_valid,
    output logic       cmd_err
);

    localparam int            DIV       = CLK_HZ / BAUD;
    localparam int            TO_CYCLES = TIMEOUT_BITS * DIV;
    localparam int            TW        = $clog2(TO_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TO_CYCLES - 1);

    dec_state_e    dec_state_q, dec_state_d;
    logic [TW-1:0] idle_cnt_q, idle_cnt_d;
    logic [5:0]    x_tmp_q, x_tmp_d;
    logic [4:0]    y_tmp_q, y_tmp_d;
    logic [5:0]    cmd_x_q, cmd_x_d;
    logic [4:0]    cmd_y_q, cmd_y_d;
    logic [1:0]    cmd_z_q, cmd_z_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic          cmd_err_q, cmd_err_d;
    logic          range_ok;

    uart_rx_byte #(
        .DIV (DIV)
    ) u_rx_byte (
        .sys_clk_i   (sys_clk_i),
        .sys_rst_n_i (sys_rst_n_i),
        .uart_rx     (uart_rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_err   (frame_err)
    );

    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_n_i) begin
            dec_state_q <= HUNT;
            idle_cnt_q  <= '0;
            x_tmp_q     <= '0;
            y_tmp_q     <= '0;
            cmd_x_q     <= '0;
            cmd_y_q     <= '0;
            cmd_z_q     <= '0;
            cmd_valid_q <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            dec_state_q <= dec_state_d;
            idle_cnt_q  <= idle_cnt_d;
            x_tmp_q     <= x_tmp_d;
            y_tmp_q     <= y_tmp_d;
            cmd_x_q     <= cmd_x_d;
            cmd_y_q     <= cmd_y_d;
            cmd_z_q     <= cmd_z_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    always_comb begin
        dec_state_d = dec_state_q;
        x_tmp_d     = x_tmp_q;
        y_tmp_d     = y_tmp_q;
        cmd_x_d     = cmd_x_q;
        cmd_y_d     = cmd_y_q;
        cmd_z_d     = cmd_z_q;
        cmd_valid_d = 1'b0;
        cmd_err_d   = 1'b0;

        // Range rule for the byte expected in the current state.
        case (dec_state_q)
            GOT_SYNC: range_ok = (rx_data <= MAX_X);
            GOT_X:    range_ok = (rx_data <= MAX_Y);
            GOT_Y:    range_ok = (rx_data[7:2] == 6'd0);
            default:  range_ok = 1'b0;
        endcase

        // Idle gap counter only runs while a packet is partially received.
        if (dec_state_q == HUNT || rx_valid) begin
            idle_cnt_d = '0;
        end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end

        if (frame_err) begin
            dec_state_d = HUNT;
        end else if (rx_valid) begin
            if (dec_state_q == HUNT) begin
                if (rx_data == SYNC_BYTE) begin
                    dec_state_d = GOT_SYNC;
                end
            end else if (range_ok) begin
                case (dec_state_q)
                    GOT_SYNC: begin
                        x_tmp_d     = rx_data[5:0];
                        dec_state_d = GOT_X;
                    end
                    GOT_X: begin
                        y_tmp_d     = rx_data[4:0];
                        dec_state_d = GOT_Y;
                    end
                    default: begin
                        cmd_x_d     = x_tmp_q;
                        cmd_y_d     = y_tmp_q;
                        cmd_z_d     = rx_data[1:0];
                        cmd_valid_d = 1'b1;
                        dec_state_d = HUNT;
                    end
                endcase
            end else begin
                // A rejected sync byte is treated as the start of a new frame.
                cmd_err_d   = 1'b1;
                dec_state_d = (rx_data == SYNC_BYTE) ? GOT_SYNC : HUNT;
            end
        end else if (dec_state_q != HUNT && idle_cnt_q == TO_LAST) begin
            cmd_err_d   = 1'b1;
            dec_state_d = HUNT;
        end
    end

    assign cmd_x     = cmd_x_q;
    assign cmd_y     = cmd_y_q;
    assign cmd_z     = cmd_z_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_rx
// Directed bench for uart_cmd_rx at default parameters (8N1, DIV = 104).
// A negedge monitor counts strobes; each scenario task compares count deltas
// and decoded fields against hand-computed values.
// ---------------------------------------------------------------------------
module tb_uart_cmd_rx;

    localparam int DIV = 104;

    logic       clk;
    logic       rst_n;
    logic       uart_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic [5:0] cmd_x;
    logic [4:0] cmd_y;
    logic [1:0] cmd_z;
    logic       cmd_valid;
    logic       cmd_err;

    int n_vec  = 0;
    int n_miss = 0;

    // Monitor state
    int         cyc   = 0;
    int         n_rx  = 0;
    int         n_fe  = 0;
    int         n_cv  = 0;
    int         n_ce  = 0;
    int         rx_cyc = 0;
    int         cv_cyc = 0;
    logic [7:0] last_rx = '0;

    // Snapshots taken by the scenario tasks
    int s_rx, s_fe, s_cv, s_ce;
    int start_cyc;

    uart_cmd_rx dut (
        .sys_clk_i   (clk),
        .sys_rst_n_i (rst_n),
        .uart_rx     (uart_rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_err   (frame_err),
        .cmd_x       (cmd_x),
        .cmd_y       (cmd_y),
        .cmd_z       (cmd_z),
        .cmd_valid   (cmd_valid),
        .cmd_err     (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            n_rx++;
            last_rx = rx_data;
            rx_cyc  = cyc;
        end
        if (frame_err === 1'b1) n_fe++;
        if (cmd_valid === 1'b1) begin
            n_cv++;
            cv_cyc = cyc;
        end
        if (cmd_err === 1'b1) n_ce++;
    end

    task automatic snap();
        s_rx = n_rx;
        s_fe = n_fe;
        s_cv = n_cv;
        s_ce = n_ce;
    endtask

    task automatic idle(input int n);
        uart_rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // One serial frame: start, 8 data bits LSB first, stop bit of given level.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        uart_rx   = 1'b0;
        start_cyc = cyc;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (DIV) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic test_reset();
        uart_rx = 1'b1;
        rst_n   = 1'b0;
        repeat (5) @(negedge clk);
        n_vec++;
        if ({rx_data, rx_valid, frame_err, cmd_x, cmd_y, cmd_z, cmd_valid, cmd_err} !== 25'd0) begin
            n_miss++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {rx_data, rx_valid, frame_err, cmd_x, cmd_y, cmd_z, cmd_valid, cmd_err});
        end
        rst_n = 1'b1;
        snap();
        idle(2000);
        n_vec++;
        if ((n_rx - s_rx) + (n_fe - s_fe) + (n_cv - s_cv) + (n_ce - s_ce) !== 0) begin
            n_miss++;
            $display("FAIL reset_quiet: got %0d strobes expected 0",
                     (n_rx - s_rx) + (n_fe - s_fe) + (n_cv - s_cv) + (n_ce - s_ce));
        end
    endtask

    task automatic test_single_byte();
        int lat;
        snap();
        send_byte(8'h55, 1'b1);
        idle(20);
        lat = rx_cyc - start_cyc;
        n_vec++;
        if (n_rx - s_rx !== 1) begin
            n_miss++;
            $display("FAIL single_count: got %0d expected 1", n_rx - s_rx);
        end
        n_vec++;
        if (last_rx !== 8'h55) begin
            n_miss++;
            $display("FAIL single_data: got %h expected 55", last_rx);
        end
        n_vec++;
        if (lat < 990 || lat > 992) begin
            n_miss++;
            $display("FAIL single_latency: got %0d expected 991 +/-1", lat);
        end
    endtask

    task automatic test_command();
        snap();
        send_byte(8'hAA, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h02, 1'b1);
        idle(10);
        n_vec++;
        if (n_rx - s_rx !== 4) begin
            n_miss++;
            $display("FAIL cmd_bytes: got %0d expected 4", n_rx - s_rx);
        end
        n_vec++;
        if (n_cv - s_cv !== 1 || n_ce - s_ce !== 0) begin
            n_miss++;
            $display("FAIL cmd_strobes: got valid=%0d err=%0d expected valid=1 err=0",
                     n_cv - s_cv, n_ce - s_ce);
        end
        n_vec++;
        if (cv_cyc - rx_cyc !== 1) begin
            n_miss++;
            $display("FAIL cmd_latency: got %0d expected 1", cv_cyc - rx_cyc);
        end
        n_vec++;
        if ({cmd_x, cmd_y, cmd_z} !== {6'd5, 5'd3, 2'd2}) begin
            n_miss++;
            $display("FAIL cmd_fields: got x=%0d y=%0d z=%0d expected x=5 y=3 z=2",
                     cmd_x, cmd_y, cmd_z);
        end
    endtask

    task automatic test_frame_err();
        snap();
        send_byte(8'hAA, 1'b0);
        idle(20);
        n_vec++;
        if (n_fe - s_fe !== 1 || n_rx - s_rx !== 0) begin
            n_miss++;
            $display("FAIL frame_err: got fe=%0d rx=%0d expected fe=1 rx=0",
                     n_fe - s_fe, n_rx - s_rx);
        end
        // A framing error mid-packet must abandon the packet.
        snap();
        send_byte(8'hAA, 1'b1);
        send_byte(8'h05, 1'b0);
        send_byte(8'h03, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h01, 1'b1);
        idle(10);
        n_vec++;
        if (n_cv - s_cv !== 0 || n_ce - s_ce !== 0 || n_fe - s_fe !== 1) begin
            n_miss++;
            $display("FAIL frame_err_hunt: got valid=%0d err=%0d fe=%0d expected 0 0 1",
                     n_cv - s_cv, n_ce - s_ce, n_fe - s_fe);
        end
    endtask

    task automatic test_glitch();
        snap();
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (30) @(negedge clk);
        idle(1200);
        n_vec++;
        if ((n_rx - s_rx) + (n_fe - s_fe) + (n_cv - s_cv) + (n_ce - s_ce) !== 0) begin
            n_miss++;
            $display("FAIL glitch: got %0d strobes expected 0",
                     (n_rx - s_rx) + (n_fe - s_fe) + (n_cv - s_cv) + (n_ce - s_ce));
        end
    endtask

    task automatic test_resync();
        snap();
        send_byte(8'hAA, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        idle(10);
        n_vec++;
        if (n_ce - s_ce !== 1 || n_cv - s_cv !== 1) begin
            n_miss++;
            $display("FAIL resync_strobes: got err=%0d valid=%0d expected err=1 valid=1",
                     n_ce - s_ce, n_cv - s_cv);
        end
        n_vec++;
        if ({cmd_x, cmd_y, cmd_z} !== {6'd1, 5'd2, 2'd3}) begin
            n_miss++;
            $display("FAIL resync_fields: got x=%0d y=%0d z=%0d expected x=1 y=2 z=3",
                     cmd_x, cmd_y, cmd_z);
        end
    endtask

    task automatic test_timeout();
        snap();
        send_byte(8'hAA, 1'b1);
        send_byte(8'h04, 1'b1);
        idle(1400);
        n_vec++;
        if (n_ce - s_ce !== 0) begin
            n_miss++;
            $display("FAIL timeout_early: got %0d expected 0", n_ce - s_ce);
        end
        idle(16 * DIV + 1 - 1400);
        n_vec++;
        if (n_ce - s_ce !== 1) begin
            n_miss++;
            $display("FAIL timeout_fire: got %0d expected 1", n_ce - s_ce);
        end
        snap();
        send_byte(8'h04, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'h01, 1'b1);
        idle(10);
        n_vec++;
        if (n_cv - s_cv !== 0 || n_ce - s_ce !== 0) begin
            n_miss++;
            $display("FAIL timeout_hunt: got valid=%0d err=%0d expected 0 0",
                     n_cv - s_cv, n_ce - s_ce);
        end
    endtask

    task automatic test_reset_mid_packet();
        snap();
        send_byte(8'hAA, 1'b1);
        send_byte(8'h05, 1'b1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({rx_data, cmd_x, cmd_y, cmd_z, cmd_valid, cmd_err} !== 23'd0) begin
            n_miss++;
            $display("FAIL midreset_outputs: got %h expected 0",
                     {rx_data, cmd_x, cmd_y, cmd_z, cmd_valid, cmd_err});
        end
        rst_n = 1'b1;
        idle(5);
        snap();
        send_byte(8'h03, 1'b1);
        send_byte(8'h02, 1'b1);
        idle(10);
        n_vec++;
        if (n_cv - s_cv !== 0 || n_ce - s_ce !== 0 || n_rx - s_rx !== 2) begin
            n_miss++;
            $display("FAIL midreset_discard: got valid=%0d err=%0d rx=%0d expected 0 0 2",
                     n_cv - s_cv, n_ce - s_ce, n_rx - s_rx);
        end
    endtask

    initial begin
        uart_rx = 1'b1;
        rst_n   = 1'b0;
        test_reset();
        test_single_byte();
        test_command();
        test_frame_err();
        test_glitch();
        test_resync();
        test_timeout();
        test_reset_mid_packet();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
